top: RTL and testbench

//  Chip top for an RS-232 LED demo on a 12 MHz board. Receives 8N1 serial bytes at 9600 baud on RX.

---
 rtl/rs232_pkg.sv | 34 +++
 rtl/uart_rx.sv | 106 ++++++++++
 rtl/top.sv | 128 ++++++++++++
 tb/tb_top.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared constants and FSM state types for the RS-232 LED demo.
// Contents:
//   CLK_HZ, BAUD  default board clock and serial rate
//   PERIOD, HALF  clocks per bit and per half bit at the default rate
//   CNT_W         width of the bit-timing down counters
//   ASCII_1/5     first/last command characters
//   rx_state_t, tx_state_t  receiver / transmitter FSM states
package rs232_pkg;

  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 9600;
  localparam int PERIOD = CLK_HZ / BAUD;
  localparam int HALF   = PERIOD / 2;
  localparam int CNT_W  = 11;

  localparam logic [7:0] ASCII_1 = 8'h31;
  localparam logic [7:0] ASCII_5 = 8'h35;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchronizer on the line plus a bit-timing FSM.
// Ports:
//   clk       system clock
//   resetn    asynchronous active-low reset
//   rx        raw serial line, idle high, asynchronous to clk
//   rx_data   last correctly framed byte (held until the next one)
//   rx_valid  one-clock strobe marking a new rx_data
// rx_valid is a strobe with no back-pressure: the consumer must act on the
// cycle it is high, because the byte is announced exactly once.
module uart_rx import rs232_pkg::*; #(
  parameter int BIT_CLKS  = PERIOD,
  parameter int HALF_CLKS = HALF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CLKS - 1);

  logic             rx_meta;
  logic             rxs;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             expired;

  assign expired = (cnt == '0);

  // Synchronizer resets to the idle level so reset release never looks
  // like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // The half-bit delay in START puts every later sample at mid-bit.
  // Returning to IDLE at mid-stop-bit leaves half a bit to catch the
  // next start edge of a back-to-back frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state <= RX_START;
            cnt   <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (!expired) begin
            cnt <= cnt - 1'b1;
          end else if (!rxs) begin
            state <= RX_DATA;
            idx   <= '0;
            cnt   <= BIT_LOAD;
          end else begin
            state <= RX_IDLE;  // line went back high: glitch, not a start bit
          end
        end
        RX_DATA: begin
          if (!expired) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg[idx] <= rxs;
            idx        <= idx + 1'b1;
            cnt        <= BIT_LOAD;
            if (idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (!expired) begin
            cnt <= cnt - 1'b1;
          end else if (rxs) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
            state    <= RX_IDLE;
          end else begin
            state <= RX_WAIT_HIGH;  // framing error: byte dropped
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/top.sv
// RS-232 LED demo chip top: bytes '1'..'5' toggle LED1..LED5 and every
// correctly framed byte is echoed back on TX.
// Ports:
//   clk        system clock (12 MHz on the board)
//   resetn     asynchronous active-low reset
//   RX         serial input, idle high
//   TX         serial output, idle high, driven straight from a flop
//   LED1..LED5 registered LED states, reset pattern 1,0,1,0,1
module top import rs232_pkg::*; #(
  parameter int CLK_HZ = rs232_pkg::CLK_HZ,
  parameter int BAUD   = rs232_pkg::BAUD
) (
  input  logic clk,
  input  logic resetn,
  input  logic RX,
  output logic TX,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5
);

  localparam int BIT_CLKS  = CLK_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(BIT_CLKS - 1);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [4:0]       led;
  logic [4:0]       led_toggle;
  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shreg;
  logic             tx_reg;
  logic             tx_expired;
  logic             tx_accept;

  uart_rx #(
    .BIT_CLKS  (BIT_CLKS),
    .HALF_CLKS (HALF_CLKS)
  ) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  // Command decode: one toggle bit per LED, only on the strobe cycle.
  always_comb begin
    led_toggle = '0;
    for (int i = 0; i < 5; i++) begin
      if (rx_valid && (rx_data == ASCII_1 + 8'(i))) led_toggle[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) led <= 5'b10101;
    else         led <= led ^ led_toggle;
  end

  assign LED1 = led[0];
  assign LED2 = led[1];
  assign LED3 = led[2];
  assign LED4 = led[3];
  assign LED5 = led[4];

  // A new echo is taken when idle, or on the very last clock of a stop bit
  // so that exactly back-to-back frames never lose their echo; in both
  // cases every bit still lasts BIT_CLKS clocks. Otherwise the echo drops.
  assign tx_expired = (tx_cnt == '0);
  assign tx_accept  = rx_valid &&
                      ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_expired));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_reg   <= 1'b1;
    end else if (tx_accept) begin
      tx_state <= TX_START;
      tx_shreg <= rx_data;
      tx_cnt   <= BIT_LOAD;
      tx_reg   <= 1'b0;
    end else begin
      case (tx_state)
        TX_START: begin
          if (!tx_expired) begin
            tx_cnt <= tx_cnt - 1'b1;
          end else begin
            tx_state <= TX_DATA;
            tx_idx   <= '0;
            tx_cnt   <= BIT_LOAD;
            tx_reg   <= tx_shreg[0];
          end
        end
        TX_DATA: begin
          if (!tx_expired) begin
            tx_cnt <= tx_cnt - 1'b1;
          end else begin
            tx_cnt <= BIT_LOAD;
            if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              tx_reg   <= 1'b1;
            end else begin
              // Shift right so the next data bit is always at [1] now, [0] next.
              tx_idx   <= tx_idx + 1'b1;
              tx_shreg <= tx_shreg >> 1;
              tx_reg   <= tx_shreg[1];
            end
          end
        end
        TX_STOP: begin
          if (!tx_expired) tx_cnt <= tx_cnt - 1'b1;
          else             tx_state <= TX_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign TX = tx_reg;

endmodule

// File: tb/tb_top.sv
// Bench for the RS-232 LED demo top. Runs at a faster baud than the board
// (100 clocks per bit) to keep the run short; all timing scales with PERIOD.
module tb_top;

  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 120000;
  localparam int PERIOD = CLK_HZ / BAUD;
  localparam int HALF   = PERIOD / 2;
  localparam int FRAME  = 10 * PERIOD;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic rx     = 1'b1;
  logic tx;
  logic led1, led2, led3, led4, led5;
  logic [4:0] leds;

  assign leds = {led5, led4, led3, led2, led1};

  always #5 clk = ~clk;

  top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .RX     (rx),
    .TX     (tx),
    .LED1   (led1),
    .LED2   (led2),
    .LED3   (led3),
    .LED4   (led4),
    .LED5   (led5)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [4:0] model_leds = 5'b10101;
  bit         led_check_en = 1'b0;
  logic [7:0] last_tx_byte = 8'h00;
  int         tx_frames = 0;
  int         frames_before;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LED model: a command character flips the LED it names.
  function automatic logic [4:0] apply_cmd(input logic [4:0] l, input logic [7:0] b);
    int n;
    n = int'(b) - 'h31;
    if (n >= 0 && n < 5) l[n] = ~l[n];
    return l;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_bits(input int n);
    repeat (n * PERIOD) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    led_check_en = 1'b0;
    if (stop_bit) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (PERIOD) @(posedge clk);
    end
    rx = 1'b1;
    if (stop_bit) model_leds = apply_cmd(model_leds, b);
    led_check_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    idle_bits(2);
  endtask

  // ---------------- compare: LEDs every cycle outside RX frames ----------------
  always @(negedge clk) begin
    if (led_check_en) check("leds", leds, model_leds);
  end

  // ---------------- compare: TX frames against expected echo ----------------
  // Every clock of a frame is compared to the ideal waveform: start bit,
  // data LSB first, stop bit, each exactly PERIOD clocks.
  logic [7:0] mon_exp;
  logic [7:0] mon_got;
  bit         mon_has_exp;
  bit         mon_abort;
  int         mon_bad;
  int         mon_bit;
  logic       mon_want;

  always begin
    @(negedge clk);
    if (resetn === 1'b1 && tx === 1'b0) begin
      mon_has_exp = (exp_q.size() > 0);
      check("tx_frame_expected", 32'(mon_has_exp), 32'd1);
      mon_exp   = mon_has_exp ? exp_q.pop_front() : 8'h00;
      mon_got   = 8'h00;
      mon_bad   = 0;
      mon_abort = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (resetn !== 1'b1) begin
          mon_abort = 1'b1;
          break;
        end
        mon_bit  = k / PERIOD;
        mon_want = (mon_bit == 0) ? 1'b0 : (mon_bit == 9) ? 1'b1 : mon_exp[mon_bit-1];
        if (tx !== mon_want) mon_bad++;
        if (mon_bit >= 1 && mon_bit <= 8 && (k % PERIOD) == HALF) mon_got[mon_bit-1] = tx;
      end
      if (!mon_abort) begin
        tx_frames++;
        last_tx_byte = mon_got;
        if (mon_has_exp) begin
          check("tx_byte", mon_got, mon_exp);
          check("tx_bit_timing_errs", mon_bad, 0);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0;
    rx     = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_leds", leds, 5'b10101);
    resetn = 1'b0;
    @(posedge clk);
    resetn = 1'b1;
    led_check_en = 1'b1;

    // 1) idle line: nothing happens
    idle_bits(10);
    check("t1_tx_idle", tx, 1'b1);
    check("t1_leds", leds, 5'b10101);
    check("t1_no_frames", tx_frames, 0);

    // 2) '1','3','5' clear the three lit LEDs
    send_byte(8'h31);
    send_byte(8'h33);
    send_byte(8'h35);
    check("t2_leds", leds, 5'b00000);

    // 3) all five twice
    for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i));
    check("t3_leds_on", leds, 5'b11111);
    for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i));
    check("t3_leds_off", leds, 5'b00000);

    // 4) non-command byte is echoed only
    send_byte(8'h41);
    idle_bits(12);
    check("t4_leds", leds, 5'b00000);
    check("t4_echo", last_tx_byte, 8'h41);

    // 5) framing error then a short glitch: no effect at all
    frames_before = tx_frames;
    send_frame(8'h32, 1'b0);
    idle_bits(2);
    rx = 1'b0;
    repeat (PERIOD / 4) @(posedge clk);
    rx = 1'b1;
    idle_bits(12);
    check("t5_leds", leds, 5'b00000);
    check("t5_no_tx", tx_frames, frames_before);

    // 6) reset in the middle of an echo
    send_frame(8'h34, 1'b1);
    #1;
    check("t6_tx_in_start_bit", tx, 1'b0);
    check("t6_led4_on", leds, 5'b01000);
    @(posedge clk);
    #2;
    resetn     = 1'b0;
    model_leds = 5'b10101;
    #1;
    check("t6_async_tx", tx, 1'b1);
    check("t6_async_leds", leds, 5'b10101);
    repeat (10) @(posedge clk);
    resetn = 1'b1;
    idle_bits(2);
    send_byte(8'h32);
    idle_bits(12);
    check("t6_leds", leds, 5'b10111);
    check("t6_echo", last_tx_byte, 8'h32);
    check("echo_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
